// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory serving CPU load/store requests with fixed latency.
// Define DMEM_BYTE_MASK_EN to honour be_i on stores; otherwise every legal store writes the full word.
module data_memory_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ready_q, ready_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem [DEPTH];
    logic        illegal;
    logic        access;
    logic [AW-1:0] idx;
    logic [3:0]  wmask;

    assign illegal = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
    assign idx     = addr_q[AW+1:2];
    assign access  = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef DMEM_BYTE_MASK_EN
    assign wmask = be_q;
`else
    // Byte enables are still latched but forced on, so every store is full-word.
    assign wmask = be_q | 4'hF;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (access) begin
                    state_d = RESP;
                    rdata_d = (we_q || illegal) ? 32'd0 : mem[idx];
                    err_d   = illegal;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        ack_d   = (state_d == RESP);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; a reset during BUSY drops state_q to IDLE so no write happens.
    always_ff @(posedge clk_i) begin
        if (access && we_q && !illegal) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign ready_o = ready_q;
    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
endmodule
